// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer: state encoding and counter sizing.
package piso_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // Bits needed to count 0..w-1. Never less than 1.
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Loadable shift register. It moves data toward the serial output end and fills vacated bits with a fixed level.
module piso_shift_reg #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             sout
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     q <= {WIDTH{IDLE_LEVEL}};
    else if (load)  q <= d;
    else if (shift) q <= MSB_FIRST ? {q[WIDTH-2:0], IDLE_LEVEL}
                                   : {IDLE_LEVEL, q[WIDTH-1:1]};
  end

  assign sout = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter. It takes words through a valid/ready handshake, and consecutive words stream with no idle gap.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             done
);

  localparam int             CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t          state;
  logic [CW-1:0]   bit_cnt;
  logic            last, xfer, sout;

  // ready depends only on registered state, so load_valid never feeds back into it
  assign last       = (state == S_SHIFT) && (bit_cnt == LAST);
  assign load_ready = (state == S_IDLE) || last;
  assign xfer       = load_valid && load_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (xfer) begin
          state   <= S_SHIFT;
          bit_cnt <= '0;
        end
        S_SHIFT: if (last) begin
          bit_cnt <= '0;
          if (!xfer) state <= S_IDLE;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .IDLE_LEVEL(IDLE_LEVEL)
  ) u_sr (
    .clk  (clk),
    .reset(reset),
    .load (xfer),
    .shift(state == S_SHIFT),
    .d    (data_in),
    .sout (sout)
  );

  assign sdo       = (state == S_SHIFT) ? sout : IDLE_LEVEL;
  assign sdo_valid = (state == S_SHIFT);
  assign done      = last;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first instance and one LSB-first instance driven by the same stimulus.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       rdy_m, sdo_m, vld_m, done_m;
  logic       rdy_l, sdo_l, vld_l, done_l;
  int         nchk = 0;
  int         nerr = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_m (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(rdy_m),
    .data_in(data_in), .sdo(sdo_m), .sdo_valid(vld_m), .done(done_m));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_l (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(rdy_l),
    .data_in(data_in), .sdo(sdo_l), .sdo_valid(vld_l), .done(done_l));

  // Advance one edge and land #1 into the following cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; load_valid = 1'b1; data_in = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      step();
      nchk++; if ({rdy_m, sdo_m, vld_m, done_m} !== 4'b1100) begin
        nerr++; $display("FAIL reset outputs cyc%0d: got rdy/sdo/vld/done=%b want 1100", i, {rdy_m, sdo_m, vld_m, done_m});
      end
    end
    load_valid = 1'b0;
    reset = 1'b1;
    step();
    nchk++; if (vld_m !== 1'b0) begin
      nerr++; $display("FAIL reset no_transfer: got sdo_valid=%b want 0", vld_m);
    end
  endtask

  task automatic test_single();
    logic [7:0] w;
    w = 8'hA5;
    data_in = w; load_valid = 1'b1;
    nchk++; if (rdy_m !== 1'b1) begin
      nerr++; $display("FAIL single ready_idle: got %b want 1", rdy_m);
    end
    step();
    load_valid = 1'b0; data_in = 8'h00;
    for (int i = 0; i < 8; i++) begin
      nchk++; if ({sdo_m, vld_m, done_m, rdy_m} !== {w[7-i], 1'b1, i == 7, i == 7}) begin
        nerr++; $display("FAIL single bit%0d: got sdo/vld/done/rdy=%b want %b", i,
                         {sdo_m, vld_m, done_m, rdy_m}, {w[7-i], 1'b1, i == 7, i == 7});
      end
      step();
    end
    nchk++; if ({sdo_m, vld_m, done_m} !== 3'b100) begin
      nerr++; $display("FAIL single after: got sdo/vld/done=%b want 100", {sdo_m, vld_m, done_m});
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] w;
    w = 8'h01;
    data_in = w; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      nchk++; if ({sdo_l, vld_l, done_l, rdy_l} !== {w[i], 1'b1, i == 7, i == 7}) begin
        nerr++; $display("FAIL lsb bit%0d: got sdo/vld/done/rdy=%b want %b", i,
                         {sdo_l, vld_l, done_l, rdy_l}, {w[i], 1'b1, i == 7, i == 7});
      end
      step();
    end
    nchk++; if ({sdo_l, vld_l} !== 2'b10) begin
      nerr++; $display("FAIL lsb after: got sdo/vld=%b want 10", {sdo_l, vld_l});
    end
  endtask

  task automatic test_back_to_back();
    int ndone;
    ndone = 0;
    data_in = 8'hFF; load_valid = 1'b1;
    step();
    data_in = 8'h00;
    for (int i = 0; i < 16; i++) begin
      nchk++; if ({sdo_m, vld_m, rdy_m} !== {i < 8, 1'b1, (i == 7) || (i == 15)}) begin
        nerr++; $display("FAIL b2b bit%0d: got sdo/vld/rdy=%b want %b", i,
                         {sdo_m, vld_m, rdy_m}, {i < 8, 1'b1, (i == 7) || (i == 15)});
      end
      if (done_m === 1'b1) ndone++;
      if (i == 8) load_valid = 1'b0;
      step();
    end
    nchk++; if (ndone != 2) begin
      nerr++; $display("FAIL b2b done_count: got %0d want 2", ndone);
    end
    nchk++; if (vld_m !== 1'b0) begin
      nerr++; $display("FAIL b2b after: got sdo_valid=%b want 0", vld_m);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] a, b;
    a = 8'h81; b = 8'h5A;
    data_in = a; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin load_valid = 1'b1; data_in = b; end
      nchk++; if ({sdo_m, rdy_m} !== {a[7-i], i == 7}) begin
        nerr++; $display("FAIL bp bit%0d: got sdo/rdy=%b want %b", i, {sdo_m, rdy_m}, {a[7-i], i == 7});
      end
      step();
    end
    load_valid = 1'b0; data_in = 8'h00;
    for (int i = 0; i < 8; i++) begin
      nchk++; if ({sdo_m, vld_m, done_m} !== {b[7-i], 1'b1, i == 7}) begin
        nerr++; $display("FAIL bp new_bit%0d: got sdo/vld/done=%b want %b", i,
                         {sdo_m, vld_m, done_m}, {b[7-i], 1'b1, i == 7});
      end
      step();
    end
    nchk++; if (vld_m !== 1'b0) begin
      nerr++; $display("FAIL bp after: got sdo_valid=%b want 0", vld_m);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] a, b;
    a = 8'hC3; b = 8'h3C;
    data_in = a; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nchk++; if (sdo_m !== a[7-i]) begin
        nerr++; $display("FAIL mrst bit%0d: got %b want %b", i, sdo_m, a[7-i]);
      end
      if (i < 4) step();
    end
    reset = 1'b0;
    #1;
    nchk++; if ({rdy_m, sdo_m, vld_m, done_m} !== 4'b1100) begin
      nerr++; $display("FAIL mrst immediate: got rdy/sdo/vld/done=%b want 1100", {rdy_m, sdo_m, vld_m, done_m});
    end
    for (int i = 0; i < 4; i++) begin
      step();
      nchk++; if ({done_m, vld_m} !== 2'b00) begin
        nerr++; $display("FAIL mrst hold%0d: got done/vld=%b want 00", i, {done_m, vld_m});
      end
    end
    reset = 1'b1;
    data_in = b; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      nchk++; if ({sdo_m, vld_m, done_m} !== {b[7-i], 1'b1, i == 7}) begin
        nerr++; $display("FAIL mrst reload_bit%0d: got sdo/vld/done=%b want %b", i,
                         {sdo_m, vld_m, done_m}, {b[7-i], 1'b1, i == 7});
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_lsb_first();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
